// File: rtl/divu_seq_if.sv
// Start/operand/result bundle for the sequential unsigned divider.
interface divu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (output start, a, b, input q, r, busy, done, div_zero);
  modport slave  (input start, a, b, output q, r, busy, done, div_zero);
endinterface

// File: rtl/divu_seq.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
//   state  | meaning
//   S_IDLE | waiting for start
//   S_RUN  | iterating, WIDTH clocks
//   S_DONE | done pulse, results valid; start re-launches
module divu_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  divu_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dz;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_dvd_nxt;
  logic             w_busy;
  logic             w_done;

  assign w_accept = bus.start && (r_state != S_RUN);
  assign w_last   = (r_cnt == CW'(1));

  // Kept remainder is always below the divisor, so WIDTH bits suffice once
  // the WIDTH+1-bit shifted value has been compared and reduced.
  assign w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_diff    = w_rem_sh[WIDTH-1:0] - r_dvs;
  assign w_rem_nxt = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
  assign w_dvd_nxt = {r_dvd[WIDTH-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_RUN:   w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd <= '0;
      r_dvs <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dz  <= 1'b0;
    end else if (w_accept) begin
      r_dvd <= bus.a;
      r_dvs <= bus.b;
      r_rem <= '0;
      r_cnt <= CW'(WIDTH);
      r_dz  <= (bus.b == '0);
    end else if (r_state == S_RUN) begin
      r_dvd <= w_dvd_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_q <= w_dvd_nxt;
        r_r <= w_rem_nxt;
      end
    end
  end

  assign bus.q        = r_q;
  assign bus.r        = r_r;
  assign bus.div_zero = r_dz;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
endmodule
